noc_local_ni: RTL

Single-clock local network interface between a processing core and a mesh router's LOCAL port. TX path packs core requests into single-flit packets and injects them into the router's local input FIFO while honouring its full flag. RX path captures ejected flits, which carry no backpressure, into a small buffer for the core. Misrouted and overflowed flits are dropped and counted.

---
 rtl/noc_local_ni.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/noc_local_ni.sv
`default_nettype none
// ============================================================================
// Module   : noc_local_ni
// Brief    : Local NI between a core and a mesh router LOCAL port. Paced TX
//            injection (1 flit / 3 cycles) and a backpressure-free RX buffer.
//            Optional NOC_NI_STATS_EN enables the drop/misroute counters.
// Revision : 1.0
// ============================================================================
module noc_local_ni #(
    parameter logic [2:0] NODE_ADDRESS = 3'd0,
    parameter int         TX_DEPTH     = 4,
    parameter int         RX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [2:0]  tx_dst,
    input  logic [25:0] tx_payload,
    output logic [31:0] LOCAL_DATA_IN,
    output logic        LOCAL_DATA_VALID_IN,
    input  logic        LOCAL_FULL_OUT,
    input  logic [31:0] LOCAL_DATA_OUT,
    input  logic        LOCAL_DATA_VALID_OUT,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [2:0]  rx_src,
    output logic [25:0] rx_payload,
    output logic [7:0]  drop_count,
    output logic [7:0]  misroute_count
);
    localparam int c_TX_PW = $clog2(TX_DEPTH);
    localparam int c_TX_CW = c_TX_PW + 1;
    localparam int c_RX_PW = $clog2(RX_DEPTH);
    localparam int c_RX_CW = c_RX_PW + 1;

    localparam logic [c_TX_CW-1:0] c_TX_FULL    = c_TX_CW'(TX_DEPTH);
    localparam logic [c_TX_CW-1:0] c_TX_CNT_ONE = c_TX_CW'(1);
    localparam logic [c_TX_PW-1:0] c_TX_PTR_ONE = c_TX_PW'(1);
    localparam logic [c_RX_CW-1:0] c_RX_FULL    = c_RX_CW'(RX_DEPTH);
    localparam logic [c_RX_CW-1:0] c_RX_CNT_ONE = c_RX_CW'(1);
    localparam logic [c_RX_PW-1:0] c_RX_PTR_ONE = c_RX_PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } inj_state_t;

    // ---------------------------------------------------------------- TX FIFO
    logic [31:0]        r_tx_mem [TX_DEPTH];
    logic [c_TX_PW-1:0] r_tx_wr_ptr;
    logic [c_TX_PW-1:0] r_tx_rd_ptr;
    logic [c_TX_CW-1:0] r_tx_count;
    logic               w_tx_push;
    logic               w_tx_pop;
    logic               w_tx_empty;

    assign tx_ready   = (r_tx_count != c_TX_FULL);
    assign w_tx_push  = tx_valid & tx_ready;
    assign w_tx_empty = (r_tx_count == '0);

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= {tx_payload, NODE_ADDRESS, tx_dst};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + c_TX_PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + c_TX_PTR_ONE;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + c_TX_CNT_ONE;
                2'b01:   r_tx_count <= r_tx_count - c_TX_CNT_ONE;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------- inject FSM
    inj_state_t r_state;
    inj_state_t w_state_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The GAP cycle gives the router time to update its full flag after a write.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_tx_empty && !LOCAL_FULL_OUT) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    logic [31:0] r_local_data;
    logic        r_local_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_local_data  <= '0;
            r_local_valid <= 1'b0;
        end else begin
            r_local_valid <= w_tx_pop;
            if (w_tx_pop) begin
                r_local_data <= r_tx_mem[r_tx_rd_ptr];
            end
        end
    end

    assign LOCAL_DATA_IN       = r_local_data;
    assign LOCAL_DATA_VALID_IN = r_local_valid;

    // ---------------------------------------------------------------- RX FIFO
    logic [28:0]        r_rx_mem [RX_DEPTH];
    logic [c_RX_PW-1:0] r_rx_wr_ptr;
    logic [c_RX_PW-1:0] r_rx_rd_ptr;
    logic [c_RX_CW-1:0] r_rx_count;
    logic               w_rx_hit;
    logic               w_rx_full;
    logic               w_rx_pop;
    logic               w_rx_push;
    logic [28:0]        w_rx_head;

    assign w_rx_hit  = LOCAL_DATA_VALID_OUT && (LOCAL_DATA_OUT[2:0] == NODE_ADDRESS);
    assign w_rx_full = (r_rx_count == c_RX_FULL);
    assign rx_valid  = (r_rx_count != '0);
    assign w_rx_pop  = rx_valid & rx_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign w_rx_push = w_rx_hit & (~w_rx_full | w_rx_pop);

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= {LOCAL_DATA_OUT[31:6], LOCAL_DATA_OUT[5:3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + c_RX_PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + c_RX_PTR_ONE;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + c_RX_CNT_ONE;
                2'b01:   r_rx_count <= r_rx_count - c_RX_CNT_ONE;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // Head is masked while empty so stale storage never shows after reset.
    assign w_rx_head  = r_rx_mem[r_rx_rd_ptr];
    assign rx_src     = rx_valid ? w_rx_head[2:0]  : 3'd0;
    assign rx_payload = rx_valid ? w_rx_head[28:3] : 26'd0;

    // ------------------------------------------------------------- statistics
`ifdef NOC_NI_STATS_EN
    logic       w_rx_drop;
    logic       w_rx_misroute;
    logic [7:0] r_drop_count;
    logic [7:0] r_misroute_count;

    assign w_rx_drop     = w_rx_hit & w_rx_full & ~w_rx_pop;
    assign w_rx_misroute = LOCAL_DATA_VALID_OUT && (LOCAL_DATA_OUT[2:0] != NODE_ADDRESS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_count     <= '0;
            r_misroute_count <= '0;
        end else begin
            if (w_rx_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            if (w_rx_misroute && (r_misroute_count != 8'hFF)) begin
                r_misroute_count <= r_misroute_count + 8'd1;
            end
        end
    end

    assign drop_count     = r_drop_count;
    assign misroute_count = r_misroute_count;
`else
    assign drop_count     = 8'd0;
    assign misroute_count = 8'd0;
`endif

endmodule
`default_nettype wire
